// File: rtl/encoder_bank_ctrl_pkg.sv
// Shared definitions for the encoder bank controller: register offsets, channel limit, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package encoder_bank_pkg;

  localparam int NUM_ENC_MAX = 8;

  // Word offsets in the register window; VALUE[i] lives at 0..NUM_ENC-1.
  localparam int REG_PENDING = 8;
  localparam int REG_MASK    = 9;
  localparam int REG_SNAP    = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/encoder_bank_ctrl_if.sv
// CPU peripheral bus bundle for the encoder bank register window.
// Latency: n/a (wiring only).
// Backpressure: req is held by the master until the slave pulses ack.
// Ports: req/wr/be/addr/wdata from master, rdata/ack from slave.
interface encoder_bank_ctrl_if #(
  parameter int ADDR_W = 4
) ();
  logic              req;
  logic              wr;
  logic [1:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic              ack;

  modport master (output req, wr, be, addr, wdata, input rdata, ack);
  modport slave  (input req, wr, be, addr, wdata, output rdata, ack);
endinterface

// File: rtl/encoder_change_detect.sv
// Per-channel change detector: previous-value register, post-preset suppression, sticky W1C pending bit.
// Latency: pending rises one cycle after enc_q_i differs from its previous sample.
// Backpressure: none; evaluates every cycle.
// Ports: enc_q_i channel value, preset_i strobe seen this cycle, clr_i W1C request, pending_o sticky flag.
module encoder_change_detect (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] enc_q_i,
  input  logic        preset_i,
  input  logic        clr_i,
  output logic        pending_o
);

  logic [15:0] prev_q, prev_d;
  logic        supp_q, supp_d;
  logic        pend_q, pend_d;
  logic        change;

  always_comb begin
    prev_d = enc_q_i;
    // The channel loads the preset on the strobe edge, so its value moves in
    // the following cycle; ignore that one comparison.
    supp_d = preset_i;
    change = (enc_q_i != prev_q) && !supp_q;
    // A new change beats a simultaneous clear.
    pend_d = change | (pend_q & ~clr_i);
  end

  // prev tracks enc_q during reset as well, so leaving reset never flags.
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
    if (!rst_n) begin
      supp_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      supp_q <= supp_d;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/encoder_bank_ctrl.sv
// Memory-mapped controller for NUM_ENC rotary-encoder channels: value read, preset, change flags, irq.
// Latency: req to ack is 2 cycles; one access per 3 cycles at most; irq lags pending/mask by 1 cycle.
// Backpressure: master holds req until ack; bus inputs are latched at access start and ignored afterwards.
// Ports: clk, rst_n (sync, active-low), bus (slave modport), enc_we/enc_din preset strobes and data,
//        enc_q live channel values, irq level interrupt.
// Option: ENC_SNAPSHOT_EN adds shadow registers captured by a SNAP write; VALUE reads then return the shadow.
module encoder_bank_ctrl
  import encoder_bank_pkg::*;
#(
  parameter int NUM_ENC = 4,
  parameter int ADDR_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  encoder_bank_ctrl_if.slave     bus,
  output logic [2*NUM_ENC-1:0]   enc_we,
  output logic [15:0]            enc_din,
  input  logic [16*NUM_ENC-1:0]  enc_q,
  output logic                   irq
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [1:0]          be_q, be_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         rdata_q, rdata_d;
  logic [NUM_ENC-1:0]  mask_q, mask_d;
  logic                irq_q, irq_d;

  logic [2*NUM_ENC-1:0] we_raw;
  logic [NUM_ENC-1:0]   pend_clr;
  logic [NUM_ENC-1:0]   pending;
  logic [15:0]          rd_mux;

`ifdef ENC_SNAPSHOT_EN
  logic [15:0] shadow_q [NUM_ENC];
  logic [15:0] shadow_d [NUM_ENC];
  logic        snap_en;
`endif

  // Read mux, evaluated in ACCESS against the latched address.
  always_comb begin
    rd_mux = 16'h0000;
    for (int i = 0; i < NUM_ENC; i++) begin
      if (addr_q == ADDR_W'(i)) begin
`ifdef ENC_SNAPSHOT_EN
        rd_mux = shadow_q[i];
`else
        rd_mux = enc_q[16*i +: 16];
`endif
      end
    end
    if (addr_q == ADDR_W'(REG_PENDING)) rd_mux = 16'(pending);
    if (addr_q == ADDR_W'(REG_MASK))    rd_mux = 16'(mask_q);
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mask_d   = mask_q;
    we_raw   = '0;
    pend_clr = '0;
`ifdef ENC_SNAPSHOT_EN
    snap_en  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          state_d = ST_ACCESS;
          addr_d  = bus.addr;
          wr_d    = bus.wr;
          be_d    = bus.be;
          // wdata_q doubles as enc_din, so it only moves on writes.
          if (bus.wr) wdata_d = bus.wdata;
        end
      end
      ST_ACCESS: begin
        state_d = ST_ACK;
        if (wr_q) begin
          for (int i = 0; i < NUM_ENC; i++) begin
            if (addr_q == ADDR_W'(i)) we_raw[2*i +: 2] = be_q;
          end
          // Flag and mask fields fit in the low byte.
          if (addr_q == ADDR_W'(REG_PENDING) && be_q[0]) pend_clr = wdata_q[NUM_ENC-1:0];
          if (addr_q == ADDR_W'(REG_MASK) && be_q[0])    mask_d   = wdata_q[NUM_ENC-1:0];
`ifdef ENC_SNAPSHOT_EN
          if (addr_q == ADDR_W'(REG_SNAP)) snap_en = 1'b1;
`endif
        end else begin
          rdata_d = rd_mux;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign irq_d = |(pending & mask_q);

`ifdef ENC_SNAPSHOT_EN
  always_comb begin
    for (int i = 0; i < NUM_ENC; i++) begin
      shadow_d[i] = snap_en ? enc_q[16*i +: 16] : shadow_q[i];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      be_q    <= 2'b00;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      mask_q  <= '0;
      irq_q   <= 1'b0;
`ifdef ENC_SNAPSHOT_EN
      for (int i = 0; i < NUM_ENC; i++) shadow_q[i] <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
`ifdef ENC_SNAPSHOT_EN
      for (int i = 0; i < NUM_ENC; i++) shadow_q[i] <= shadow_d[i];
`endif
    end
  end

  for (genvar g = 0; g < NUM_ENC; g++) begin : g_cd
    encoder_change_detect u_cd (
      .clk       (clk),
      .rst_n     (rst_n),
      .enc_q_i   (enc_q[16*g +: 16]),
      .preset_i  (|enc_we[2*g +: 2]),
      .clr_i     (pend_clr[g]),
      .pending_o (pending[g])
    );
  end

  // Reset asserted mid-access kills the strobe in that same cycle.
  assign enc_we    = rst_n ? we_raw : '0;
  assign enc_din   = wdata_q;
  assign bus.ack   = (state_q == ST_ACK);
  assign bus.rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_encoder_bank_ctrl.sv
// Directed self-checking bench for encoder_bank_ctrl with a simple encoder load model.
// Latency: n/a.
// Backpressure: n/a.
module tb_encoder_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  enc_we;
  logic [15:0] enc_din;
  logic [63:0] enc_q;
  logic        irq;
  logic [15:0] ch [4];
  logic [7:0]  we_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign enc_q = {ch[3], ch[2], ch[1], ch[0]};

  encoder_bank_ctrl_if #(.ADDR_W(4)) bus_if ();

  encoder_bank_ctrl #(.NUM_ENC(4), .ADDR_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .enc_we  (enc_we),
    .enc_din (enc_din),
    .enc_q   (enc_q),
    .irq     (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge; the encoder model
  // loads strobed byte lanes at that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (we_pend[2*i])   ch[i][7:0]  = enc_din[7:0];
      if (we_pend[2*i+1]) ch[i][15:8] = enc_din[15:8];
    end
    we_pend = 8'h00;
  endtask

  task automatic xfer(input logic w, input logic [3:0] a, input logic [1:0] b,
                      input logic [15:0] d, input bit bump0,
                      output logic [15:0] rd, output int lat,
                      output logic [7:0] we_seen, output int we_cyc);
    rd = 16'h0000; lat = 0; we_seen = 8'h00; we_cyc = 0;
    tick();
    bus_if.req = 1'b1; bus_if.wr = w; bus_if.addr = a; bus_if.be = b; bus_if.wdata = d;
    while (lat < 10) begin
      tick();
      lat++;
      if (lat == 1) begin
        // Scramble the bus after the latch point; the access must not notice.
        bus_if.wr = ~w; bus_if.addr = 4'hF; bus_if.be = ~b; bus_if.wdata = ~d;
        if (bump0) ch[0] = ch[0] + 16'd1;
      end
      if (enc_we != 8'h00) begin
        we_seen = we_seen | enc_we;
        we_cyc++;
      end
      we_pend = enc_we;
      if (bus_if.ack) begin
        rd = bus_if.rdata;
        break;
      end
    end
    bus_if.req = 1'b0;
  endtask

  logic [15:0] rd;
  int          lat, we_cyc;
  logic [7:0]  we_seen;

  initial begin
    ch[0] = 16'd5; ch[1] = 16'h0123; ch[2] = 16'h0000; ch[3] = 16'd10;
    we_pend = 8'h00;
    rst_n = 1'b0;
    bus_if.req = 1'b0; bus_if.wr = 1'b0; bus_if.be = 2'b00; bus_if.addr = 4'h0; bus_if.wdata = 16'h0000;
    repeat (3) tick();
    chk("rst_rdata", 32'(bus_if.rdata), 32'h0);
    chk("rst_ack", 32'(bus_if.ack), 32'h0);
    chk("rst_enc_we", 32'(enc_we), 32'h0);
    chk("rst_enc_din", 32'(enc_din), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;

    xfer(1'b0, 4'd8, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("rst_pending", 32'(rd), 32'h0);

    // Live read of VALUE[1]; the SNAP write makes the snapshot build agree.
    xfer(1'b1, 4'd10, 2'b11, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    xfer(1'b0, 4'd1, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("rd1_latency", 32'(lat), 32'd2);
    chk("rd1_data", 32'(rd), 32'h0123);
    tick();
    chk("ack_one_cycle", 32'(bus_if.ack), 32'h0);
    chk("rdata_held", 32'(bus_if.rdata), 32'h0123);

    // Preset channel 2.
    xfer(1'b1, 4'd2, 2'b11, 16'h1FFF, 1'b0, rd, lat, we_seen, we_cyc);
    chk("wr2_latency", 32'(lat), 32'd2);
    chk("wr2_enc_we", 32'(we_seen), 32'h30);
    chk("wr2_we_cycles", 32'(we_cyc), 32'd1);
    chk("wr2_enc_din", 32'(enc_din), 32'h1FFF);
    xfer(1'b1, 4'd3, 2'b01, 16'h0077, 1'b0, rd, lat, we_seen, we_cyc);
    chk("wr3_lo_enc_we", 32'(we_seen), 32'h40);
    xfer(1'b0, 4'd8, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("preset_no_flag", 32'(rd), 32'h0);

    // Mask + change detect + irq timing.
    xfer(1'b1, 4'd9, 2'b01, 16'h0001, 1'b0, rd, lat, we_seen, we_cyc);
    xfer(1'b0, 4'd9, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("mask_rd", 32'(rd), 32'h1);
    tick();
    ch[0] = 16'd6;
    tick();
    chk("irq_delay", 32'(irq), 32'h0);
    tick();
    chk("irq_set", 32'(irq), 32'h1);
    xfer(1'b0, 4'd8, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("pending_set", 32'(rd), 32'h1);

    // W1C clears, irq drops one cycle later.
    xfer(1'b1, 4'd8, 2'b01, 16'h0001, 1'b0, rd, lat, we_seen, we_cyc);
    tick();
    chk("irq_clr", 32'(irq), 32'h0);
    xfer(1'b0, 4'd8, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("pending_clr", 32'(rd), 32'h0);

    // Clear collides with a fresh change: set wins.
    ch[0] = 16'd7;
    tick(); tick();
    xfer(1'b1, 4'd8, 2'b01, 16'h0001, 1'b1, rd, lat, we_seen, we_cyc);
    xfer(1'b0, 4'd8, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("w1c_set_wins", 32'(rd), 32'h1);
    chk("w1c_irq_kept", 32'(irq), 32'h1);

    // Snapshot versus live value.
    ch[3] = 16'd10;
    tick();
    xfer(1'b1, 4'd10, 2'b11, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    ch[3] = 16'd20;
    tick();
    xfer(1'b0, 4'd3, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
`ifdef ENC_SNAPSHOT_EN
    chk("snap_value3", 32'(rd), 32'd10);
`else
    chk("snap_value3", 32'(rd), 32'd20);
`endif
    xfer(1'b0, 4'd10, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("snap_rd_zero", 32'(rd), 32'h0);
    xfer(1'b0, 4'd5, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("unmapped5_rd", 32'(rd), 32'h0);
    xfer(1'b0, 4'd15, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("unmapped15_rd", 32'(rd), 32'h0);
    xfer(1'b1, 4'd5, 2'b11, 16'hFFFF, 1'b0, rd, lat, we_seen, we_cyc);
    chk("unmapped_wr_lat", 32'(lat), 32'd2);
    chk("unmapped_wr_we", 32'(we_seen), 32'h0);

    // Reset during ACCESS.
    tick();
    bus_if.req = 1'b1; bus_if.wr = 1'b1; bus_if.addr = 4'd1; bus_if.be = 2'b11; bus_if.wdata = 16'hBEEF;
    tick();
    chk("mid_we_before", 32'(enc_we), 32'h0C);
    rst_n = 1'b0;
    #1;
    chk("mid_we_in_rst", 32'(enc_we), 32'h0);
    bus_if.req = 1'b0;
    tick();
    chk("mid_no_ack", 32'(bus_if.ack), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("mid_no_ack2", 32'(bus_if.ack), 32'h0);
    chk("mid_we_after", 32'(enc_we), 32'h0);
    chk("mid_ch1_kept", 32'(ch[1]), 32'h0123);
    xfer(1'b1, 4'd10, 2'b11, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("post_rst_lat", 32'(lat), 32'd2);
    xfer(1'b0, 4'd1, 2'b00, 16'h0, 1'b0, rd, lat, we_seen, we_cyc);
    chk("post_rst_rd", 32'(rd), 32'h0123);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
